// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_hold slice.
// Contents: FSM state type (IDLE/HOLD) and the 2-bit code values that
// map onto the one-hot output lines w/x/y/z.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] CODE_W = 2'b00;
  localparam logic [1:0] CODE_X = 2'b01;
  localparam logic [1:0] CODE_Y = 2'b10;
  localparam logic [1:0] CODE_Z = 2'b11;

endpackage

// File: rtl/decoder_hold_if.sv
// Code-input handshake bundle for decoder_hold.
// Signals: in_valid (source -> decoder), in_ready (decoder -> source),
//          e1/e0 (2-bit code), p (even-parity bit, only when
//          DECODER_PARITY_EN is defined).
// Modports: master = code source, slave = decoder.
interface decoder_hold_if;

  logic in_valid;
  logic in_ready;
  logic e0;
  logic e1;
`ifdef DECODER_PARITY_EN
  logic p;

  modport master (output in_valid, output e0, output e1, output p, input in_ready);
  modport slave  (input in_valid, input e0, input e1, input p, output in_ready);
`else
  modport master (output in_valid, output e0, output e1, input in_ready);
  modport slave  (input in_valid, input e0, input e1, output in_ready);
`endif

endinterface

// File: rtl/decoder_hold_dec2to4.sv
// dec2to4: purely combinational 2-bit code to one-hot decode.
// Ports: code  in  2  code {e1,e0}
//        onehot out 4 one-hot line select, bit0=w, bit1=x, bit2=y, bit3=z
module dec2to4
  import decoder_pkg::*;
(
  input  logic [1:0] code,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    case (code)
      CODE_W:  onehot = 4'b0001;
      CODE_X:  onehot = 4'b0010;
      CODE_Y:  onehot = 4'b0100;
      CODE_Z:  onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  end

endmodule

// File: rtl/decoder_hold.sv
// decoder_hold: clocked 2-to-4 decoder with valid/ready handshake. Each
// accepted code raises exactly one of w/x/y/z for HOLD_CYCLES cycles.
// A new code may be accepted on the last held cycle, so consecutive codes
// produce contiguous strobes with no gap.
// Ports: clk, rst_n (async active-low), bus (decoder_hold_if.slave:
//        in_valid/in_ready/e1/e0[/p]), w/x/y/z one-hot strobes, busy,
//        err (parity-error pulse, only with DECODER_PARITY_EN).
// Optional feature macro: DECODER_PARITY_EN (adds p input and err output).
module decoder_hold
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_hold_if.slave  bus,
  output logic           w,
  output logic           x,
  output logic           y,
  output logic           z,
`ifdef DECODER_PARITY_EN
  output logic           err,
`endif
  output logic           busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       onehot_reg, onehot_next;
  logic [3:0]       dec_onehot;
  logic             in_ready_int;
  logic             xfer;
  logic             code_ok;

  dec2to4 u_dec (
    .code   ({bus.e1, bus.e0}),
    .onehot (dec_onehot)
  );

  // cnt is 0 whenever we are IDLE, but keep the state test explicit.
  assign in_ready_int = (state_reg == IDLE) || (cnt_reg == '0);
  assign xfer         = bus.in_valid && in_ready_int;

`ifdef DECODER_PARITY_EN
  // Even parity: p must equal e1 ^ e0 for the code to be decoded.
  assign code_ok = (bus.p == (bus.e1 ^ bus.e0));

  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else        err_reg <= xfer && !code_ok;
  end

  assign err = err_reg;
`else
  assign code_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      onehot_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      onehot_reg <= onehot_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    onehot_next = onehot_reg;
    case (state_reg)
      IDLE: begin
        // A bad-parity code is consumed but leaves us IDLE.
        if (xfer && code_ok) begin
          state_next  = HOLD;
          onehot_next = dec_onehot;
          cnt_next    = RELOAD;
        end
      end
      HOLD: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (xfer && code_ok) begin
          // Back-to-back reload: switch lines on this edge, no gap cycle.
          onehot_next = dec_onehot;
          cnt_next    = RELOAD;
        end else begin
          state_next  = IDLE;
          onehot_next = '0;
        end
      end
      default: begin
        state_next  = IDLE;
        onehot_next = '0;
        cnt_next    = '0;
      end
    endcase
  end

  // Outputs: decoded directly from registers
  always_comb begin
    w            = onehot_reg[0];
    x            = onehot_reg[1];
    y            = onehot_reg[2];
    z            = onehot_reg[3];
    busy         = (state_reg == HOLD);
    bus.in_ready = in_ready_int;
  end

endmodule

// File: tb/tb_decoder_hold.sv
// Testbench for decoder_hold: one instance with HOLD_CYCLES=4 driven from
// a vector table, one with HOLD_CYCLES=1 for single-cycle streaming, plus
// hand-written sequences for reset and (optionally) parity errors.
module tb_decoder_hold;

  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  decoder_hold_if if4 ();
  decoder_hold_if if1 ();

  logic w4, x4, y4, z4, busy4, err4;
  logic w1, x1, y1, z1, busy1, err1;

  decoder_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave),
    .w     (w4),
    .x     (x4),
    .y     (y4),
    .z     (z4),
`ifdef DECODER_PARITY_EN
    .err   (err4),
`endif
    .busy  (busy4)
  );

  decoder_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave),
    .w     (w1),
    .x     (x1),
    .y     (y1),
    .z     (z1),
`ifdef DECODER_PARITY_EN
    .err   (err1),
`endif
    .busy  (busy1)
  );

`ifndef DECODER_PARITY_EN
  assign err4 = 1'b0;
  assign err1 = 1'b0;
`endif

  // Line patterns packed {w,x,y,z}
  localparam logic [3:0] LN = 4'b0000;
  localparam logic [3:0] LW = 4'b1000;
  localparam logic [3:0] LX = 4'b0100;
  localparam logic [3:0] LY = 4'b0010;
  localparam logic [3:0] LZ = 4'b0001;

  // One table entry = inputs driven this cycle + outputs expected this cycle
  // (before the coming rising edge). exp = {w,x,y,z,busy,in_ready,err}.
  typedef struct {
    logic       v;
    logic [1:0] code;
    logic [6:0] exp;
  } vec_t;

  vec_t vq[$];

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(logic v, logic [1:0] c, logic [3:0] line,
                              logic b, logic r);
    vec_t t;
    t.v    = v;
    t.code = c;
    t.exp  = {line, b, r, 1'b0};
    return t;
  endfunction

  function automatic logic [3:0] line_of(logic [1:0] c);
    logic [3:0] l;
    case (c)
      2'b00:   l = LW;
      2'b01:   l = LX;
      2'b10:   l = LY;
      default: l = LZ;
    endcase
    return l;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got wxyz_busy_rdy_err=%b want=%b t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s wxyz_busy_rdy_err=%b t=%0t", name, act, $time);
    end
  endtask

  function automatic logic [6:0] obs4();
    return {w4, x4, y4, z4, busy4, if4.in_ready, err4};
  endfunction

  function automatic logic [6:0] obs1();
    return {w1, x1, y1, z1, busy1, if1.in_ready, err1};
  endfunction

  task automatic drive4(input logic v, input logic [1:0] c, input logic par);
    if4.in_valid = v;
    if4.e1       = c[1];
    if4.e0       = c[0];
`ifdef DECODER_PARITY_EN
    if4.p        = par;
`else
    if (par) begin end
`endif
  endtask

  task automatic drive1(input logic v, input logic [1:0] c);
    if1.in_valid = v;
    if1.e1       = c[1];
    if1.e0       = c[0];
`ifdef DECODER_PARITY_EN
    if1.p        = c[1] ^ c[0];
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive4(1'b0, 2'b00, 1'b0);
    drive1(1'b0, 2'b00);

    // ---------------- Vector table for HOLD_CYCLES=4 ----------------
    // Single code 10, with a code 11 presented while not ready (ignored).
    vq.push_back(mk(1, 2'b10, LN, 0, 1));
    vq.push_back(mk(0, 2'b00, LY, 1, 0));
    vq.push_back(mk(1, 2'b11, LY, 1, 0));
    vq.push_back(mk(0, 2'b00, LY, 1, 0));
    vq.push_back(mk(0, 2'b00, LY, 1, 1));
    vq.push_back(mk(0, 2'b00, LN, 0, 1));
    // Back-to-back 00, 01, 11 with valid held high.
    vq.push_back(mk(1, 2'b00, LN, 0, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1, 2'b00, LW, 1, 0));
    vq.push_back(mk(1, 2'b01, LW, 1, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1, 2'b01, LX, 1, 0));
    vq.push_back(mk(1, 2'b11, LX, 1, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1, 2'b11, LZ, 1, 0));
    vq.push_back(mk(0, 2'b00, LZ, 1, 1));
    // Same code twice: w stays high for 8 continuous cycles.
    vq.push_back(mk(1, 2'b00, LN, 0, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1, 2'b00, LW, 1, 0));
    vq.push_back(mk(1, 2'b00, LW, 1, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 2'b00, LW, 1, 0));
    vq.push_back(mk(0, 2'b00, LW, 1, 1));
    vq.push_back(mk(0, 2'b00, LN, 0, 1));

    // ---------------- Reset ----------------
    #1;
    check("reset4", obs4(), {LN, 1'b0, 1'b1, 1'b0});
    check("reset1", obs1(), {LN, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle4_%0d", i), obs4(), {LN, 1'b0, 1'b1, 1'b0});
    end
    check("idle1", obs1(), {LN, 1'b0, 1'b1, 1'b0});

    // ---------------- Table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive4(vq[i].v, vq[i].code, vq[i].code[1] ^ vq[i].code[0]);
      check($sformatf("vec%0d", i), obs4(), vq[i].exp);
    end
    drive4(1'b0, 2'b00, 1'b0);

    // ---------------- HOLD_CYCLES=1 streaming ----------------
    for (int i = 0; i < 8; i++) begin
      logic [1:0] c;
      logic [1:0] prev;
      c    = 2'(i);
      prev = 2'(i - 1);
      @(negedge clk);
      drive1(1'b1, c);
      if (i == 0) check("h1_0", obs1(), {LN, 1'b0, 1'b1, 1'b0});
      else        check($sformatf("h1_%0d", i), obs1(), {line_of(prev), 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    drive1(1'b0, 2'b00);
    check("h1_last", obs1(), {LZ, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    check("h1_idle", obs1(), {LN, 1'b0, 1'b1, 1'b0});

    // ---------------- Mid-hold asynchronous reset ----------------
    @(negedge clk);
    drive4(1'b1, 2'b01, 1'b1);
    @(negedge clk);
    drive4(1'b0, 2'b00, 1'b0);
    check("mh_x_on", obs4(), {LX, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mh_before_rst", obs4(), {LX, 1'b1, 1'b0, 1'b0});
    #1;
    rst_n = 1'b0;
    #1;
    check("mh_async_clear", obs4(), {LN, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mh_idle_after", obs4(), {LN, 1'b0, 1'b1, 1'b0});

`ifdef DECODER_PARITY_EN
    // ---------------- Parity ----------------
    drive4(1'b1, 2'b11, 1'b1);
    @(negedge clk);
    drive4(1'b0, 2'b00, 1'b0);
    check("par_err", obs4(), {LN, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    check("par_err_gone", obs4(), {LN, 1'b0, 1'b1, 1'b0});
    drive4(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive4(1'b0, 2'b00, 1'b0);
      check($sformatf("par_ok_%0d", i), obs4(), {LZ, 1'b1, (i == 3), 1'b0});
    end
    @(negedge clk);
    check("par_ok_idle", obs4(), {LN, 1'b0, 1'b1, 1'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
